// File: rtl/fxp_pkg.sv
// Shared fixed-point definitions for the divider and the multiplier.
package fxp_pkg;

    localparam int FXP_DATA_WIDTH = 16;
    localparam int FXP_BIN_POS    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } fxp_state_t;

    // Largest positive value of a w-bit two's complement word, zero-extended to 64 bits.
    function automatic logic [63:0] fxp_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Bit pattern of the most negative w-bit value (also its magnitude), zero-extended.
    function automatic logic [63:0] fxp_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/fxp_sat_sign.sv
// Unsigned magnitude plus sign to saturated signed DATA_WIDTH result.
module fxp_sat_sign
    import fxp_pkg::*;
#(
    parameter int DATA_WIDTH = FXP_DATA_WIDTH,
    parameter int MAG_WIDTH  = FXP_DATA_WIDTH + FXP_BIN_POS
) (
    input  logic [MAG_WIDTH-1:0]  mag,
    input  logic                  neg,
    output logic [DATA_WIDTH-1:0] result
);

    localparam logic [DATA_WIDTH-1:0] MAX_VAL = DATA_WIDTH'(fxp_max(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] MIN_VAL = DATA_WIDTH'(fxp_min(DATA_WIDTH));
    localparam logic [MAG_WIDTH-1:0]  MAX_MAG = MAG_WIDTH'(fxp_max(DATA_WIDTH));
    localparam logic [MAG_WIDTH-1:0]  MIN_MAG = MAG_WIDTH'(fxp_min(DATA_WIDTH));

    // Zero never becomes -0; negative side may reach exactly 2^(W-1) before clipping.
    always_comb begin
        result = '0;
        if (mag == '0) begin
            result = '0;
        end else if (!neg) begin
            result = (mag > MAX_MAG) ? MAX_VAL : mag[DATA_WIDTH-1:0];
        end else begin
            result = (mag > MIN_MAG) ? MIN_VAL : (~mag[DATA_WIDTH-1:0] + 1'b1);
        end
    end

endmodule

// File: rtl/fxp_div.sv
// Signed fixed-point restoring divider: quot = (a << BIN_POS) / b, one bit per clock.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for start; operands captured on accept
// ST_RUN  | one shift/trial-subtract per clock, N clocks
// ST_FIX  | apply sign and saturation, register result, pulse done
module fxp_div
    import fxp_pkg::*;
#(
    parameter int DATA_WIDTH = FXP_DATA_WIDTH,
    parameter int BIN_POS    = FXP_BIN_POS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quot,
    output logic                  div_by_zero
);

    localparam int N     = DATA_WIDTH + BIN_POS;
    localparam int CNT_W = $clog2(N + 1);

    localparam logic [DATA_WIDTH-1:0] MAX_VAL = DATA_WIDTH'(fxp_max(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] MIN_VAL = DATA_WIDTH'(fxp_min(DATA_WIDTH));

    fxp_state_t state_q, state_d;

    logic [N-1:0]          num_q;
    logic [DATA_WIDTH:0]   rem_q;
    logic [N-1:0]          quo_q;
    logic [DATA_WIDTH-1:0] den_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  neg_q;
    logic                  dz_q;

    logic                  accept;
    logic                  step;
    logic                  finish;
    logic [DATA_WIDTH-1:0] a_mag;
    logic [DATA_WIDTH-1:0] b_mag;
    logic                  b_zero;
    logic [DATA_WIDTH:0]   rem_shift;
    logic [DATA_WIDTH:0]   rem_trial;
    logic                  fits;
    logic [DATA_WIDTH-1:0] sat_q;

    // Operand magnitudes; |MIN| lands exactly on 2^(W-1) as an unsigned value.
    always_comb begin
        a_mag  = a[DATA_WIDTH-1] ? (~a + 1'b1) : a;
        b_mag  = b[DATA_WIDTH-1] ? (~b + 1'b1) : b;
        b_zero = (b == '0);
    end

    // One restoring step: bring in the next numerator bit and try to subtract |b|.
    always_comb begin
        rem_shift = {rem_q[DATA_WIDTH-1:0], num_q[N-1]};
        fits      = (rem_shift >= {1'b0, den_q});
        rem_trial = rem_shift - {1'b0, den_q};
    end

    fxp_sat_sign #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAG_WIDTH  (N)
    ) u_sat (
        .mag    (quo_q),
        .neg    (neg_q),
        .result (sat_q)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = b_zero ? ST_FIX : ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                finish  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs; done is a single-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            den_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            dz_q        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quot        <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                num_q <= N'(a_mag) << BIN_POS;
                rem_q <= '0;
                quo_q <= '0;
                den_q <= b_mag;
                cnt_q <= CNT_W'(N);
                dz_q  <= b_zero;
                // For divide-by-zero only the dividend sign picks MAX or MIN.
                neg_q <= b_zero ? a[DATA_WIDTH-1] : (a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1]);
                busy  <= 1'b1;
            end
            if (step) begin
                num_q <= num_q << 1;
                rem_q <= fits ? rem_trial : rem_shift;
                quo_q <= {quo_q[N-2:0], fits};
                cnt_q <= cnt_q - 1'b1;
            end
            if (finish) begin
                quot        <= dz_q ? (neg_q ? MIN_VAL : MAX_VAL) : sat_q;
                div_by_zero <= dz_q;
                done        <= 1'b1;
                busy        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fxp_div.sv
// Directed table-driven bench for fxp_div (DATA_WIDTH=16, BIN_POS=8).
module tb_fxp_div;

    localparam int LIMIT = 60;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] quot;
    logic        div_by_zero;

    int n_vec  = 0;
    int n_fail = 0;
    logic [15:0] last_q = 16'h0000;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic        dz;
        int          lat;
    } vec_t;

    fxp_div #(.DATA_WIDTH(16), .BIN_POS(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .quot        (quot),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called 1 time unit after an edge; start is seen by the following edge.
    task automatic launch(input logic [15:0] va, input logic [15:0] vb);
        a     = va;
        b     = vb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input logic [15:0] exp_q, input logic exp_dz,
                             input int exp_lat, input logic [15:0] prev_q, input bit pulse);
        int cycles;
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
            if (pulse) begin
                start = (cycles == 3) || (cycles == 10);
                if (start) begin
                    a = 16'h0100;
                    b = 16'h0000;
                end
            end
            if (cycles == 2 && exp_lat > 2) check({name, " hold"}, {16'h0, quot}, {16'h0, prev_q});
        end while (!done && cycles < LIMIT);
        start = 1'b0;
        check({name, " latency"}, cycles, exp_lat);
        check({name, " quot"}, {16'h0, quot}, {16'h0, exp_q});
        check({name, " dz"}, {31'h0, div_by_zero}, {31'h0, exp_dz});
        check({name, " busy@done"}, {31'h0, busy}, 32'h0);
    endtask

    vec_t vecs[$];

    initial begin
        int extra_done;

        vecs.push_back('{16'h0300, 16'h0200, 16'h0180, 1'b0, 25}); //  3 / 2
        vecs.push_back('{16'hFD00, 16'h0200, 16'hFE80, 1'b0, 25}); // -3 / 2
        vecs.push_back('{16'h0100, 16'h0300, 16'h0055, 1'b0, 25}); //  1 / 3
        vecs.push_back('{16'h7F00, 16'h0080, 16'h7FFF, 1'b0, 25}); // 127 / 0.5
        vecs.push_back('{16'h8000, 16'h0080, 16'h8000, 1'b0, 25}); // -128 / 0.5
        vecs.push_back('{16'hFF00, 16'h0000, 16'h8000, 1'b1, 1});  // -1 / 0
        vecs.push_back('{16'h0000, 16'h0000, 16'h7FFF, 1'b1, 1});  //  0 / 0
        vecs.push_back('{16'h0100, 16'hFD00, 16'hFFAB, 1'b0, 25}); //  1 / -3
        vecs.push_back('{16'h0000, 16'hFB00, 16'h0000, 1'b0, 25}); //  0 / -5
        vecs.push_back('{16'h8000, 16'h8000, 16'h0100, 1'b0, 25}); // MIN / MIN
        vecs.push_back('{16'h8000, 16'hFF00, 16'h7FFF, 1'b0, 25}); // -128 / -1
        vecs.push_back('{16'h4000, 16'h0080, 16'h7FFF, 1'b0, 25}); // +128 clips
        vecs.push_back('{16'hC000, 16'h0080, 16'h8000, 1'b0, 25}); // -128 exact
        vecs.push_back('{16'hFFFF, 16'h0002, 16'hFF80, 1'b0, 25}); // -0.5
        vecs.push_back('{16'hFFFF, 16'h7FFF, 16'h0000, 1'b0, 25}); // tiny negative -> 0
        vecs.push_back('{16'h7FFF, 16'h7FFF, 16'h0100, 1'b0, 25}); // x / x
        vecs.push_back('{16'h0A00, 16'h0400, 16'h0280, 1'b0, 25}); // 10 / 4
        vecs.push_back('{16'h0100, 16'hFFFF, 16'h8000, 1'b0, 25}); // 1 / -lsb clips

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        check("reset busy", {31'h0, busy}, 32'h0);
        check("reset done", {31'h0, done}, 32'h0);
        check("reset quot", {16'h0, quot}, 32'h0);
        check("reset dz",   {31'h0, div_by_zero}, 32'h0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            launch(vecs[i].a, vecs[i].b);
            check($sformatf("v%0d busy", i), {31'h0, busy}, 32'h1);
            wait_done($sformatf("v%0d", i), vecs[i].q, vecs[i].dz, vecs[i].lat, last_q, 1'b0);
            last_q = vecs[i].q;
            @(posedge clk);
            #1;
            check($sformatf("v%0d done pulse", i), {31'h0, done}, 32'h0);
            check($sformatf("v%0d quot held", i), {16'h0, quot}, {16'h0, last_q});
        end

        // Start pulses mid-operation are dropped, nothing queued behind them.
        launch(16'h0300, 16'h0200);
        wait_done("ignored start", 16'h0180, 1'b0, 25, last_q, 1'b1);
        last_q = 16'h0180;
        extra_done = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done) extra_done++;
        end
        check("no queued op", extra_done, 0);
        check("ignored quot held", {16'h0, quot}, {16'h0, last_q});

        // Start raised in the done cycle is accepted.
        launch(16'h0A00, 16'h0400);
        wait_done("b2b first", 16'h0280, 1'b0, 25, last_q, 1'b0);
        last_q = 16'h0280;
        launch(16'hFD00, 16'h0200);
        check("b2b accept busy", {31'h0, busy}, 32'h1);
        check("b2b accept done low", {31'h0, done}, 32'h0);
        wait_done("b2b second", 16'hFE80, 1'b0, 25, last_q, 1'b0);
        last_q = 16'hFE80;

        // A divide-by-zero result must not survive a reset either.
        @(posedge clk);
        #1;
        launch(16'h0100, 16'h0000);
        wait_done("dz before reset", 16'h7FFF, 1'b1, 1, last_q, 1'b0);
        last_q = 16'h7FFF;

        // Reset during RUN aborts at once and returns outputs to reset values.
        @(posedge clk);
        #1;
        launch(16'h0300, 16'h0200);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort busy", {31'h0, busy}, 32'h0);
        check("abort done", {31'h0, done}, 32'h0);
        check("abort quot", {16'h0, quot}, 32'h0);
        check("abort dz",   {31'h0, div_by_zero}, 32'h0);
        extra_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (done) extra_done++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) extra_done++;
        end
        check("no done after abort", extra_done, 0);
        last_q = 16'h0000;
        launch(16'h0100, 16'h0300);
        wait_done("after abort", 16'h0055, 1'b0, 25, last_q, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
